// File: rtl/div64_seq_if.sv
// Request/response bundle for the sequential divider: operands and start in,
// registered results and status out.
interface div64_seq_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_zero
  );
endinterface

// File: rtl/div64_seq.sv
// Unsigned restoring divider, one quotient bit per clock; done is seen WIDTH+1
// edges after acceptance (divide-by-zero: 1). start is only sampled while idle.
module div64_seq #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  div64_seq_if.slave  i_div
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_zero;

  logic [WIDTH:0]   w_shift_hi;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic             w_last;

  // Upper part kept at WIDTH+1 bits so the remainder MSB survives the shift.
  assign w_shift_hi = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = w_shift_hi - {1'b0, r_div};
  assign w_borrow   = w_trial[WIDTH];
  assign w_rem_nxt  = w_borrow ? w_shift_hi[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nxt  = {r_quo[WIDTH-2:0], ~w_borrow};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_div.start) begin
          w_state_nxt = (i_div.divisor == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_div.start) begin
            r_div <= i_div.divisor;
            r_rem <= '0;
            r_quo <= i_div.dividend;
            r_cnt <= '0;
            if (i_div.divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= i_div.dividend;
              r_div_zero  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
          // Results publish on the same edge as the final step.
          if (w_last) begin
            r_quotient  <= w_quo_nxt;
            r_remainder <= w_rem_nxt;
            r_div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign i_div.quotient  = r_quotient;
  assign i_div.remainder = r_remainder;
  assign i_div.div_zero  = r_div_zero;
  assign i_div.busy      = (r_state != S_IDLE);
  assign i_div.done      = (r_state == S_DONE);

endmodule

// File: tb/tb_div64_seq.sv
// Directed bench for div64_seq: a quotient/remainder model built on / and %
// is compared every cycle, plus literal expectations per operation.
module tb_div64_seq;
  localparam int WIDTH = 64;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;

  div64_seq_if #(.WIDTH(WIDTH)) bus ();

  div64_seq #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_div (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: external timing plus exact integer division.
  logic        m_busy, m_done, m_dz;
  logic [63:0] m_q, m_r, m_pq, m_pr;
  int          m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_q <= '0; m_r <= '0; m_pq <= '0; m_pr <= '0; m_left <= 0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy <= 1'b1;
        if (bus.divisor == 64'd0) begin
          m_done <= 1'b1; m_q <= ALL1; m_r <= bus.dividend; m_dz <= 1'b1;
        end else begin
          m_left <= WIDTH;
          m_pq   <= bus.dividend / bus.divisor;
          m_pr   <= bus.dividend % bus.divisor;
        end
      end
    end else if (m_done) begin
      m_done <= 1'b0; m_busy <= 1'b0;
    end else if (m_left == 1) begin
      m_done <= 1'b1; m_q <= m_pq; m_r <= m_pr; m_dz <= 1'b0; m_left <= 0;
    end else begin
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", {63'd0, bus.busy}, {63'd0, m_busy});
    chk("cyc_done", {63'd0, bus.done}, {63'd0, m_done});
    chk("cyc_divzero", {63'd0, bus.div_zero}, {63'd0, m_dz});
    chk("cyc_quotient", bus.quotient, m_q);
    chk("cyc_remainder", bus.remainder, m_r);
  end

  // Entered just after an edge; returns at the negedge where done is seen.
  task automatic wait_done(inout int lat, output int bcnt, output bit ok);
    ok = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.done) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string nm, input logic [63:0] eq, input logic [63:0] er,
                              input bit edz);
    chk({nm, "_quotient"}, bus.quotient, eq);
    chk({nm, "_remainder"}, bus.remainder, er);
    chk({nm, "_divzero"}, {63'd0, bus.div_zero}, {63'd0, edz});
  endtask

  task automatic run_op(input string nm, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eq, input logic [63:0] er, input bit edz,
                        input int elat, input int ebusy);
    int lat, bc;
    bit ok;
    @(posedge clk); #2;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #2;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    lat = 1;
    wait_done(lat, bc, ok);
    chk({nm, "_done_seen"}, {63'd0, ok}, 64'd1);
    chk({nm, "_latency"}, 64'(lat), 64'(elat));
    chk({nm, "_busy_cycles"}, 64'(bc), 64'(ebusy));
    check_result(nm, eq, er, edz);
  endtask

  initial begin
    int lat, bc, t1, t2;
    bit ok;
    n_checks = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #2;
    check_result("reset", 64'd0, 64'd0, 1'b0);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    rst_n = 1'b1;

    run_op("d100_7", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65, 65);
    run_op("msb_div", ALL1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 65, 65);
    run_op("by_one", ALL1, 64'd1, ALL1, 64'd0, 1'b0, 65, 65);
    run_op("small", 64'd5, 64'd9, 64'd0, 64'd5, 1'b0, 65, 65);
    run_op("divzero", 64'h1234, 64'd0, ALL1, 64'h1234, 1'b1, 1, 1);
    run_op("clear_dz", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65, 65);

    // A start pulse mid-calculation must be ignored.
    @(posedge clk); #2;
    bus.start = 1'b1; bus.dividend = 64'd100; bus.divisor = 64'd7;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    bus.start = 1'b1; bus.dividend = 64'd50; bus.divisor = 64'd5;
    @(posedge clk); #2;
    bus.start = 1'b0;
    lat = 11;
    wait_done(lat, bc, ok);
    chk("ignore_done_seen", {63'd0, ok}, 64'd1);
    chk("ignore_latency", 64'(lat), 64'd65);
    check_result("ignore", 64'd14, 64'd2, 1'b0);
    repeat (4) @(negedge clk);
    chk("ignore_not_queued", {63'd0, bus.busy}, 64'd0);

    // start held high: back-to-back runs with a one-cycle idle gap.
    @(posedge clk); #2;
    bus.start = 1'b1; bus.dividend = 64'd100; bus.divisor = 64'd7;
    lat = 0;
    wait_done(lat, bc, ok);
    chk("held_first_done", {63'd0, ok}, 64'd1);
    t1 = cyc;
    wait_done(lat, bc, ok);
    chk("held_second_done", {63'd0, ok}, 64'd1);
    t2 = cyc;
    chk("held_period", 64'(t2 - t1), 64'd66);
    check_result("held", 64'd14, 64'd2, 1'b0);
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_stopped", {63'd0, bus.busy}, 64'd0);

    // Reset in the middle of a calculation discards it.
    @(posedge clk); #2;
    bus.start = 1'b1; bus.dividend = 64'd100; bus.divisor = 64'd7;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (29) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_result("midreset", 64'd0, 64'd0, 1'b0);
    chk("midreset_busy", {63'd0, bus.busy}, 64'd0);
    chk("midreset_done", {63'd0, bus.done}, 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (70) begin
      @(negedge clk);
      if (bus.done) chk("midreset_no_done", 64'd1, 64'd0);
    end
    run_op("after_reset", 64'd81, 64'd9, 64'd9, 64'd0, 1'b0, 65, 65);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, limit 2000000 reached");
    $fatal(1);
  end
endmodule
